// File: rtl/mmio_io_device_if.sv
// rtl/mmio_io_device_if.sv - data-memory bus interface for the IO window responder
// The decoder/CPU side drives the access; the IO device returns combinational load data.
interface mmio_io_device_if;
  logic        en;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output memRead, output memWrite, output addr, output wdata, input rdata);
  modport slave  (input en, input memRead, input memWrite, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_io_device.sv
// rtl/mmio_io_device.sv - IO window: button event FIFO, FIFO status, ms timer, LED register
// Loads are combinational; every state change happens on the rising clock edge.
module mmio_io_device #(
  parameter int BTN_W           = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CYCLES_PER_MS   = 50000,
  parameter int LED_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  mmio_io_device_if.slave     bus,
  input  logic [BTN_W-1:0]    btn,
  output logic [LED_W-1:0]    leds
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;

  logic [BTN_W-1:0] sync1, sync2, db, dbNext, rise;
  logic [DW-1:0]    dbCnt   [BTN_W];
  logic [DW-1:0]    cntNext [BTN_W];
  logic [7:0]       pressCode;
  logic             pressAny, pressExtra;

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [AW-1:0]    rdPtr, wrPtr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [31:0]      countExt;

  logic [31:0]      ms;
  logic [PW-1:0]    presc;

  logic             rdSel, wrSel, full, pop, push, ovfSet, ovfClr;
  logic             timerWr, ledWr;
  logic [1:0]       regSel;
  logic             unusedBits;

  assign rdSel    = bus.en & bus.memRead;
  assign wrSel    = bus.en & bus.memWrite;
  assign regSel   = bus.addr[3:2];
  assign countExt = 32'(count);
  assign unusedBits = ^{bus.addr[31:4], bus.addr[1:0], countExt[31:4]};

  // Counter only runs while the synchronized level disagrees with the accepted level.
  always_comb begin
    dbNext = db;
    for (int i = 0; i < BTN_W; i++) begin
      cntNext[i] = '0;
      if (sync2[i] != db[i]) begin
        if (dbCnt[i] == DW'(DEBOUNCE_CYCLES - 1)) dbNext[i] = sync2[i];
        else cntNext[i] = dbCnt[i] + DW'(1);
      end
    end
    rise = dbNext & ~db;
  end

  always_comb begin
    pressCode = '0;
    for (int i = BTN_W - 1; i >= 0; i--) begin
      if (rise[i]) pressCode = 8'(i);
    end
    pressAny   = |rise;
    pressExtra = (rise & (rise - BTN_W'(1))) != '0;
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rdSel && (regSel == 2'd0) && (count != '0);
  // A same-edge pop frees the slot, so a push into a full FIFO is still accepted.
  assign push    = pressAny && (!full || pop);
  assign ovfSet  = pressExtra || (pressAny && full && !pop);
  assign ovfClr  = wrSel && (regSel == 2'd1) && bus.wdata[31];
  assign timerWr = wrSel && (regSel == 2'd2);
  assign ledWr   = wrSel && (regSel == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db       <= '0;
      for (int i = 0; i < BTN_W; i++) dbCnt[i] <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ms       <= '0;
      presc    <= '0;
      leds     <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db    <= dbNext;
      for (int i = 0; i < BTN_W; i++) dbCnt[i] <= cntNext[i];

      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      // A new overflow on the same edge as a clear is kept so no loss goes unreported.
      if (ovfSet)      overflow <= 1'b1;
      else if (ovfClr) overflow <= 1'b0;

      if (timerWr) begin
        ms    <= bus.wdata;
        presc <= '0;
      end else if (presc == PW'(CYCLES_PER_MS - 1)) begin
        ms    <= ms + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      if (ledWr) leds <= bus.wdata[LED_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= pressCode;
  end

  always_comb begin
    bus.rdata = '0;
    if (rdSel) begin
      case (regSel)
        2'd0:    if (count != '0) bus.rdata = {1'b1, 23'b0, fifoMem[rdPtr]};
        2'd1:    bus.rdata = {overflow, 27'b0, countExt[3:0]};
        2'd2:    bus.rdata = ms;
        default: bus.rdata = 32'(leds);
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_device.sv
// tb/tb_mmio_io_device.sv - randomized and directed bench for mmio_io_device
// A queue/arithmetic model predicts rdata and leds; a negedge process compares every cycle.
module tb_mmio_io_device;
  localparam int BTN_W = 4;
  localparam int DEPTH = 4;
  localparam int DEB   = 4;
  localparam int CPM   = 10;
  localparam int LED_W = 16;

  logic             clk;
  logic             rst;
  logic [BTN_W-1:0] btn;
  logic [LED_W-1:0] leds;
  int               tests = 0;
  int               fails = 0;

  mmio_io_device_if busIf();

  mmio_io_device #(
    .BTN_W(BTN_W), .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB),
    .CYCLES_PER_MS(CPM), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(busIf), .btn(btn), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: level history, a code queue and elapsed-cycle timer arithmetic.
  logic [BTN_W-1:0] mS1, mS2, mDb, mNewDb, mRise;
  logic [BTN_W-1:0] mHist [DEB];
  logic [7:0]       mQ [$];
  logic             mOvf, mOvfSet, mPop, mFull, mAllDiff;
  logic [31:0]      mLoad;
  longint unsigned  mCyc;
  logic [LED_W-1:0] mLeds;
  logic [7:0]       mCode;

  function automatic logic [31:0] modelMs();
    return mLoad + 32'(mCyc / CPM);
  endfunction

  function automatic logic [31:0] expRdata();
    if (!(busIf.en && busIf.memRead)) return 32'h0;
    case (busIf.addr[3:2])
      2'd0:    return (mQ.size() > 0) ? {1'b1, 23'b0, mQ[0]} : 32'h0;
      2'd1:    return {mOvf, 27'b0, 4'(mQ.size())};
      2'd2:    return modelMs();
      default: return 32'(mLeds);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mS1 = '0; mS2 = '0; mDb = '0;
      for (int j = 0; j < DEB; j++) mHist[j] = '0;
      mQ.delete();
      mOvf = 1'b0; mLoad = '0; mCyc = 0; mLeds = '0;
    end else begin
      for (int j = DEB - 1; j > 0; j--) mHist[j] = mHist[j-1];
      mHist[0] = mS2;
      mNewDb = mDb;
      for (int i = 0; i < BTN_W; i++) begin
        mAllDiff = 1'b1;
        for (int j = 0; j < DEB; j++) if (mHist[j][i] == mDb[i]) mAllDiff = 1'b0;
        if (mAllDiff) mNewDb[i] = ~mDb[i];
      end
      mRise = mNewDb & ~mDb;
      mDb = mNewDb; mS2 = mS1; mS1 = btn;

      mFull = (mQ.size() == DEPTH);
      mPop  = busIf.en && busIf.memRead && busIf.addr[3:2] == 2'd0 && mQ.size() > 0;
      mOvfSet = 1'b0;
      if (mPop) void'(mQ.pop_front());
      if (mRise != '0) begin
        mCode = 8'hFF;
        for (int i = BTN_W - 1; i >= 0; i--) if (mRise[i]) mCode = 8'(i);
        if (!mFull || mPop) mQ.push_back(mCode);
        else mOvfSet = 1'b1;
        if ($countones(mRise) > 1) mOvfSet = 1'b1;
      end
      if (busIf.en && busIf.memWrite && busIf.addr[3:2] == 2'd1 && busIf.wdata[31]) mOvf = 1'b0;
      if (mOvfSet) mOvf = 1'b1;

      if (busIf.en && busIf.memWrite && busIf.addr[3:2] == 2'd2) begin
        mLoad = busIf.wdata; mCyc = 0;
      end else begin
        mCyc++;
      end
      if (busIf.en && busIf.memWrite && busIf.addr[3:2] == 2'd3) mLeds = busIf.wdata[LED_W-1:0];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model rdata", busIf.rdata, expRdata());
      check("model leds", 32'(leds), 32'(mLeds));
    end
  end

  task automatic idleBus();
    busIf.en = 1'b0; busIf.memRead = 1'b0; busIf.memWrite = 1'b0;
    busIf.addr = '0; busIf.wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
    busIf.en = 1'b1; busIf.memRead = 1'b1; busIf.memWrite = 1'b0; busIf.addr = a;
    #2;
    check(nm, busIf.rdata, exp);
    idleBus();
  endtask

  task automatic rdPop(input logic [31:0] a, input logic [31:0] exp, input string nm);
    busIf.en = 1'b1; busIf.memRead = 1'b1; busIf.memWrite = 1'b0; busIf.addr = a;
    #2;
    check(nm, busIf.rdata, exp);
    idle(1);
    idleBus();
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    busIf.en = 1'b1; busIf.memRead = 1'b0; busIf.memWrite = 1'b1;
    busIf.addr = a; busIf.wdata = d;
    idle(1);
    idleBus();
  endtask

  initial begin
    idleBus();
    btn = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;

    peek(32'h4, 32'h0, "reset status");
    peek(32'h0, 32'h0, "reset event");
    peek(32'hC, 32'h0, "reset led");
    check("reset leds port", 32'(leds), 32'h0);

    // Timer after reset
    idle(9);
    peek(32'h8, 32'h0, "timer edge9");
    idle(1);
    peek(32'h8, 32'h1, "timer edge10");

    // Debounce latency and event read
    btn[2] = 1'b1;
    idle(5);
    peek(32'h4, 32'h0, "status before debounce");
    idle(1);
    peek(32'h4, 32'h1, "status after debounce");
    rdPop(32'h0, 32'h80000002, "event btn2");
    peek(32'h4, 32'h0, "status after pop");
    btn[2] = 1'b0;
    idle(8);
    peek(32'h4, 32'h0, "release no event");
    btn[1] = 1'b1;
    idle(3);
    btn[1] = 1'b0;
    idle(8);
    peek(32'h4, 32'h0, "glitch no event");

    // Overflow, clear, and same-edge push/pop on a full FIFO
    for (int p = 0; p < 5; p++) begin
      btn[0] = 1'b1; idle(7);
      btn[0] = 1'b0; idle(7);
    end
    peek(32'h4, 32'h80000004, "status overflow");
    busWrite(32'h4, 32'h80000000);
    peek(32'h4, 32'h00000004, "status cleared");
    btn[0] = 1'b1;
    idle(5);
    rdPop(32'h0, 32'h80000000, "event same edge");
    peek(32'h4, 32'h00000004, "full push+pop");
    btn[0] = 1'b0;
    idle(7);
    for (int p = 0; p < 4; p++) rdPop(32'h0, 32'h80000000, "drain");
    peek(32'h0, 32'h0, "drained event");

    // Simultaneous presses
    btn = 4'b1010;
    idle(6);
    peek(32'h4, 32'h80000001, "simul status");
    rdPop(32'h0, 32'h80000001, "simul event");
    busWrite(32'h4, 32'h80000000);
    btn = '0;
    idle(7);

    // Timer load and wrap
    busWrite(32'h8, 32'hFFFFFFFF);
    peek(32'h8, 32'hFFFFFFFF, "timer loaded");
    idle(9);
    peek(32'h8, 32'hFFFFFFFF, "timer pre wrap");
    idle(1);
    peek(32'h8, 32'h0, "timer wrapped");

    // LED and bus gating
    busWrite(32'hC, 32'h1234ABCD);
    check("leds port", 32'(leds), 32'h0000ABCD);
    peek(32'hC, 32'h0000ABCD, "led read");
    busIf.en = 1'b0; busIf.memWrite = 1'b1; busIf.addr = 32'hC; busIf.wdata = 32'h5555;
    idle(1);
    idleBus();
    check("leds en0", 32'(leds), 32'h0000ABCD);
    busIf.en = 1'b1; busIf.memRead = 1'b0; busIf.addr = 32'hC;
    #2;
    check("rdata memRead0", busIf.rdata, 32'h0);
    idleBus();
    busWrite(32'h0, 32'h12345678);
    peek(32'h4, 32'h0, "event write status");
    peek(32'h0, 32'h0, "event write event");

    // Asynchronous reset between edges
    btn[0] = 1'b1; idle(7); btn[0] = 1'b0; idle(7);
    btn[3] = 1'b1; idle(7); btn[3] = 1'b0; idle(7);
    busWrite(32'h8, 32'h7);
    busWrite(32'hC, 32'hFFFF);
    peek(32'h4, 32'h2, "pre reset status");
    peek(32'h8, 32'h7, "pre reset timer");
    #2 rst = 1'b1;
    #1;
    check("async leds", 32'(leds), 32'h0);
    busIf.en = 1'b1; busIf.memRead = 1'b1; busIf.addr = 32'h4;
    #1 check("async status", busIf.rdata, 32'h0);
    busIf.addr = 32'h8;
    #1 check("async timer", busIf.rdata, 32'h0);
    busIf.addr = 32'h0;
    #1 check("async event", busIf.rdata, 32'h0);
    idleBus();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < BTN_W; i++) if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
      busIf.en       = ($urandom_range(0, 3) != 0);
      busIf.memRead  = $urandom_range(0, 1) == 1;
      busIf.memWrite = ($urandom_range(0, 3) == 0);
      busIf.addr     = $urandom;
      busIf.wdata    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : $urandom;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
      idle(1);
    end
    idleBus();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
